// File: rtl/vga_pkg.sv
// Shared timing defaults, types and derived-constant helpers for the VGA output path.
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel clock
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;

  localparam int unsigned CNT_W = 12;

  typedef logic [15:0]      pixel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Total period of a line or frame (H_TOT / V_TOT)
  function automatic int unsigned total_len(input int unsigned sync, input int unsigned back,
                                            input int unsigned active, input int unsigned front);
    return sync + back + active + front;
  endfunction

  // First active position in a line or frame (HA0 / VA0)
  function automatic int unsigned active_start(input int unsigned sync, input int unsigned back);
    return sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// Generic sync/porch/active position counter; one instance per axis.
module vga_sync_cnt
  import vga_pkg::*;
#(
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BACK   = H_BACK_DEF,
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FRONT  = H_FRONT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output cnt_t count,
  output logic wrap,
  output logic sync_active,
  output logic active
);

  localparam cnt_t LAST     = cnt_t'(total_len(SYNC, BACK, ACTIVE, FRONT) - 1);
  localparam cnt_t SYNC_END = cnt_t'(SYNC);
  localparam cnt_t ACT_LO   = cnt_t'(active_start(SYNC, BACK));
  localparam cnt_t ACT_HI   = cnt_t'(active_start(SYNC, BACK) + ACTIVE);

  assign wrap        = enable && (count == LAST);
  assign sync_active = (count < SYNC_END);
  assign active      = (count >= ACT_LO) && (count < ACT_HI);

  // Position counter, advances on enable and wraps at the end of the period
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: pixel request one cycle ahead, registered sync and RGB565 pins.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  pixel_t      pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output pixel_t      rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam int unsigned HA0 = active_start(H_SYNC, H_BACK);
  localparam int unsigned VA0 = active_start(V_SYNC, V_BACK);

  // Request window is the active span shifted one clock earlier
  localparam cnt_t REQ_LO = cnt_t'(HA0 - 1);
  localparam cnt_t REQ_HI = cnt_t'(HA0 + H_ACTIVE - 2);
  localparam cnt_t Y_OFS  = cnt_t'(VA0);

  cnt_t h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic h_sync_act, v_sync_act;
  logic h_active, v_active;
  logic h_req;
  logic unused_ok;

  vga_sync_cnt #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_cnt (
    .clk         (vga_clk),
    .rst         (sys_rst),
    .enable      (1'b1),
    .count       (h_cnt),
    .wrap        (h_wrap),
    .sync_active (h_sync_act),
    .active      (h_active)
  );

  vga_sync_cnt #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_cnt (
    .clk         (vga_clk),
    .rst         (sys_rst),
    .enable      (h_wrap),
    .count       (v_cnt),
    .wrap        (v_wrap),
    .sync_active (v_sync_act),
    .active      (v_active)
  );

  // Horizontal active flag and frame wrap are not needed at this level
  assign unused_ok = h_active ^ v_wrap;

  // Combinational request; drops in the same cycle reset is asserted
  always_comb begin
    h_req   = (h_cnt >= REQ_LO) && (h_cnt <= REQ_HI);
    pix_req = h_req && v_active && !sys_rst;
    pix_x   = '0;
    pix_y   = '0;
    if (pix_req) begin
      pix_x = 10'(h_cnt - REQ_LO);
      pix_y = 10'(v_cnt - Y_OFS);
    end
  end

  // Pin registers: all share a one-cycle lag behind the counters
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb         <= '0;
      rgb_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= v_sync_act ? SYNC_POL : ~SYNC_POL;
      rgb         <= pix_req ? pix_data : '0;
      rgb_valid   <= pix_req;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl using a reduced timing set so whole frames run quickly.
module tb_vga_ctrl;

  // Reduced timing: line = 4+3+8+2 = 17 clocks, frame = 2+2+4+1 = 9 lines
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1;
  localparam int HT  = 17;
  localparam int VT  = 9;
  localparam int FT  = HT * VT;   // 153
  localparam int HA0 = 7;
  localparam int VA0 = 4;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [15:0] pix_data;
  logic        pix_req;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync;
  logic [15:0] rgb;
  logic        rgb_valid;
  logic        frame_start;
  logic        white;

  int errors = 0;
  int checks = 0;

  // statistics over the first two frames
  int valid_cnt = 0, fs_cnt = 0, vs_low = 0, hs_low = 0;
  int first_req_n = -1;
  int first_x = -1, first_y = -1;
  int max_x = -1, max_y = -1;

  vga_ctrl #(
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .H_ACTIVE (HA),
    .H_FRONT  (HF),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_ACTIVE (VA),
    .V_FRONT  (VF),
    .SYNC_POL (1'b0)
  ) dut (
    .vga_clk     (clk),
    .sys_rst     (sys_rst),
    .pix_data    (pix_data),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Upstream pixel source: pattern derived from the requested coordinates
  assign pix_data = white ? 16'hFFFF : {pix_x[4:0], pix_y[5:0], pix_x[4:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input int x, input int y);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    return {xx[4:0], yy[5:0], xx[4:0]};
  endfunction

  // Checks one sample n cycles after edge 0 (taken on the falling edge)
  task automatic step(input int n);
    int c, h, v, c1, h1, v1;
    logic ev, er;
    logic [15:0] erg;
    c  = n % FT;      h  = c % HT;  v  = c / HT;
    c1 = (n + 1) % FT; h1 = c1 % HT; v1 = c1 / HT;
    ev  = (h >= HA0 - 1) && (h <= HA0 + HA - 2) && (v >= VA0) && (v < VA0 + VA);
    er  = (h1 >= HA0 - 1) && (h1 <= HA0 + HA - 2) && (v1 >= VA0) && (v1 < VA0 + VA);
    erg = ev ? (white ? 16'hFFFF : pattern(h - (HA0 - 1), v - VA0)) : 16'h0000;
    chk($sformatf("hsync n=%0d", n),       32'(hsync),       32'(h >= HS));
    chk($sformatf("vsync n=%0d", n),       32'(vsync),       32'(v >= VS));
    chk($sformatf("frame_start n=%0d", n), 32'(frame_start), 32'(c == 0));
    chk($sformatf("rgb_valid n=%0d", n),   32'(rgb_valid),   32'(ev));
    chk($sformatf("rgb n=%0d", n),         32'(rgb),         32'(erg));
    chk($sformatf("pix_req n=%0d", n),     32'(pix_req),     32'(er));
    chk($sformatf("pix_x n=%0d", n),       32'(pix_x),       er ? 32'(h1 - (HA0 - 1)) : 32'd0);
    chk($sformatf("pix_y n=%0d", n),       32'(pix_y),       er ? 32'(v1 - VA0) : 32'd0);
    if (n < 2 * FT) begin
      valid_cnt += int'(rgb_valid);
      fs_cnt    += int'(frame_start);
      vs_low    += int'(!vsync);
      if (n < 3 * HT) hs_low += int'(!hsync);
      if (pix_req) begin
        if (first_req_n < 0) begin
          first_req_n = n;
          first_x = int'(pix_x);
          first_y = int'(pix_y);
        end
        if (int'(pix_x) > max_x) max_x = int'(pix_x);
        if (int'(pix_y) > max_y) max_y = int'(pix_y);
      end
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    white   = 1'b0;

    // Reset held: pins idle, no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("rst hsync %0d", i),       32'(hsync),       32'd1);
      chk($sformatf("rst vsync %0d", i),       32'(vsync),       32'd1);
      chk($sformatf("rst rgb %0d", i),         32'(rgb),         32'd0);
      chk($sformatf("rst rgb_valid %0d", i),   32'(rgb_valid),   32'd0);
      chk($sformatf("rst frame_start %0d", i), 32'(frame_start), 32'd0);
      chk($sformatf("rst pix_req %0d", i),     32'(pix_req),     32'd0);
    end

    // Two frames of the coordinate pattern
    sys_rst = 1'b0;
    for (int n = 0; n < 2 * FT; n++) begin
      @(negedge clk);
      step(n);
    end

    chk("valid cycles 2 frames", 32'(valid_cnt), 32'(2 * HA * VA));
    chk("frame_start pulses",    32'(fs_cnt),    32'd2);
    chk("vsync low cycles",      32'(vs_low),    32'(2 * VS * HT));
    chk("hsync low 3 lines",     32'(hs_low),    32'(3 * HS));
    chk("first req sample",      32'(first_req_n), 32'd73);
    chk("first req pix_x",       32'(first_x),   32'd0);
    chk("first req pix_y",       32'(first_y),   32'd0);
    chk("last pix_x",            32'(max_x),     32'd7);
    chk("last pix_y",            32'(max_y),     32'd3);

    // Third frame with an all-white source: blanking must stay black
    white = 1'b1;
    for (int n = 2 * FT; n < 3 * FT; n++) begin
      @(negedge clk);
      step(n);
    end

    // Run into row 2 until pix_x = 3 is requested, then pulse reset
    white = 1'b0;
    for (int n = 3 * FT; n <= 3 * FT + 110; n++) begin
      @(negedge clk);
      step(n);
    end
    chk("pre-reset pix_x", 32'(pix_x), 32'd3);
    chk("pre-reset pix_y", 32'(pix_y), 32'd2);
    sys_rst = 1'b1;
    #1;
    chk("reset pix_req comb", 32'(pix_req), 32'd0);
    chk("reset pix_x comb",   32'(pix_x),   32'd0);
    @(negedge clk);
    chk("mid-rst rgb_valid",   32'(rgb_valid),   32'd0);
    chk("mid-rst rgb",         32'(rgb),         32'd0);
    chk("mid-rst hsync",       32'(hsync),       32'd1);
    chk("mid-rst vsync",       32'(vsync),       32'd1);
    chk("mid-rst frame_start", 32'(frame_start), 32'd0);

    // Restart from edge 0 after release
    sys_rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      step(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
